// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel memory-to-memory DMA.
package dma_pkg;

  localparam int CNT_W = 16;
  localparam int AW    = 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_CNT  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_ABORT    = 2;
  localparam int CTRL_CLR_DONE = 3;

endpackage

// File: rtl/dma_regs.sv
// DMA register file (SRC/DST/CNT/CTRL-STAT) and responder read mux.
// Define DMA_IRQ_EN to get a registered irq = done & irq_en; otherwise irq is 0.
module dma_regs
  import dma_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [1:0]       addr_i,
  input  logic [31:0]      data_i,
  input  logic             busy_i,
  input  logic             src_inc_i,
  input  logic             dst_inc_i,
  input  logic             cnt_dec_i,
  input  logic             set_done_i,
  output logic [31:0]      data_o,
  output logic [AW-1:0]    src_o,
  output logic [AW-1:0]    dst_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             start_o,
  output logic             abort_o,
  output logic             irq_o
);

  logic [AW-1:0]    src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_en_q, irq_en_d, done_q, done_d;
  logic             cfg_wr, ctrl_wr;
  logic             unused_data_hi;

  assign unused_data_hi = ^data_i[31:24];

  // SRC/DST/CNT are frozen while a transfer owns them.
  assign cfg_wr  = stb_i & we_i & ~busy_i;
  assign ctrl_wr = stb_i & we_i & (addr_i == REG_CTRL);
  assign start_o = ctrl_wr & data_i[CTRL_START];
  assign abort_o = ctrl_wr & data_i[CTRL_ABORT] & busy_i;

  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    if (cfg_wr && addr_i == REG_SRC) src_d = data_i[23:2];
    else if (src_inc_i)              src_d = src_q + {{(AW-1){1'b0}}, 1'b1};
    if (cfg_wr && addr_i == REG_DST) dst_d = data_i[23:2];
    else if (dst_inc_i)              dst_d = dst_q + {{(AW-1){1'b0}}, 1'b1};
    if (cfg_wr && addr_i == REG_CNT) cnt_d = data_i[CNT_W-1:0];
    else if (cnt_dec_i)              cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    if (ctrl_wr) irq_en_d = data_i[CTRL_IRQ_EN];
    // A completion landing together with a clear-done wins.
    if (set_done_i)                               done_d = 1'b1;
    else if (ctrl_wr && data_i[CTRL_CLR_DONE])    done_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    data_o = 32'h0;
    case (addr_i)
      REG_SRC:  data_o = {8'h0, src_q, 2'b00};
      REG_DST:  data_o = {8'h0, dst_q, 2'b00};
      REG_CNT:  data_o = {{(32-CNT_W){1'b0}}, cnt_q};
      default:  data_o = {29'h0, irq_en_q, done_q, busy_i};
    endcase
  end

  assign src_o = src_q;
  assign dst_o = dst_q;
  assign cnt_o = cnt_q;

`ifdef DMA_IRQ_EN
  logic irq_q;
  // Built from next-state values so irq tracks done/irq_en without extra lag.
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= done_d & irq_en_d;
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: rtl/dma.sv
// Single-channel word DMA: responder register port plus an initiator that
// alternates read/write bus cycles. Optional irq via the DMA_IRQ_EN macro.
module dma
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [3:2]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq,
  output logic        m_stb,
  output logic        m_we,
  output logic [23:2] m_addr,
  input  logic [31:0] m_din,
  output logic [31:0] m_dout,
  input  logic        m_ack
);

  state_e           state_q, state_d;
  logic             gap_q, gap_d, abort_q, abort_d;
  logic [31:0]      buf_q, buf_d;
  logic [AW-1:0]    src, dst;
  logic [CNT_W-1:0] cnt;
  logic             busy, start, abort_req, abort_pend, ack_ok;
  logic             src_inc, dst_inc, cnt_dec, set_done;

  dma_regs u_regs (
    .clk        (clk),
    .rst        (rst),
    .stb_i      (stb),
    .we_i       (we),
    .addr_i     (addr),
    .data_i     (data_in),
    .busy_i     (busy),
    .src_inc_i  (src_inc),
    .dst_inc_i  (dst_inc),
    .cnt_dec_i  (cnt_dec),
    .set_done_i (set_done),
    .data_o     (data_out),
    .src_o      (src),
    .dst_o      (dst),
    .cnt_o      (cnt),
    .start_o    (start),
    .abort_o    (abort_req),
    .irq_o      (irq)
  );

  assign ack        = stb;
  assign busy       = (state_q != IDLE);
  // gap_q forces one idle bus cycle after every completed transaction.
  assign m_stb      = ((state_q == RD) || (state_q == WR)) && !gap_q;
  assign ack_ok     = m_stb & m_ack;
  assign gap_d      = ack_ok;
  assign abort_pend = abort_q | abort_req;
  assign m_dout     = buf_q;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    abort_d  = 1'b0;
    m_we     = 1'b0;
    m_addr   = src;
    src_inc  = 1'b0;
    dst_inc  = 1'b0;
    cnt_dec  = 1'b0;
    set_done = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = (cnt == '0) ? FIN : RD;
      RD: begin
        abort_d = abort_pend;
        if (gap_q) begin
          if (abort_pend) state_d = FIN;
        end else if (m_ack) begin
          buf_d   = m_din;
          src_inc = 1'b1;
          state_d = abort_pend ? FIN : WR;
        end
      end
      WR: begin
        abort_d = abort_pend;
        m_we    = 1'b1;
        m_addr  = dst;
        if (gap_q) begin
          if (abort_pend) state_d = FIN;
        end else if (m_ack) begin
          dst_inc = 1'b1;
          cnt_dec = 1'b1;
          state_d = (abort_pend || cnt == {{(CNT_W-1){1'b0}}, 1'b1}) ? FIN : RD;
        end
      end
      FIN: begin
        set_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= 1'b0;
      abort_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      abort_q <= abort_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_dma.sv
// Scoreboard bench for dma: expected bus transactions and register reads are
// queued by the stimulus and compared by a separate negedge monitor.
module tb_dma;

  logic        clk, rst, stb, we, ack, irq;
  logic [3:2]  addr;
  logic [31:0] data_in, data_out, m_din, m_dout;
  logic        m_stb, m_we, m_ack;
  logic [23:2] m_addr;

  dma dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ack(ack), .irq(irq),
    .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_din(m_din),
    .m_dout(m_dout), .m_ack(m_ack)
  );

  typedef struct packed {
    logic        we;
    logic [21:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t        bus_q[$];
  logic [31:0] rd_q[$];
  string       rd_n[$];
  logic [31:0] mem [logic [21:0]];
  int          checks = 0;
  int          errors = 0;
  int          stb_seen = 0;
  logic        hold = 0;
  logic        exp_irq;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // Memory responder: acks one cycle after m_stb rises unless held off.
  initial begin
    int wcnt;
    wcnt  = 0;
    m_ack = 0;
    m_din = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || m_ack || !m_stb) begin
        m_ack = 0;
        wcnt  = 0;
      end else if (!hold) begin
        if (wcnt == 1) begin
          m_ack = 1;
          if (m_we) mem[m_addr] = m_dout;
          else m_din = mem.exists(m_addr) ? mem[m_addr] : 32'hDEAD_BEEF;
        end else wcnt++;
      end
    end
  end

  // Monitor: one line per completed transaction.
  initial begin
    txn_t t;
    logic [31:0] e;
    string n;
    forever begin
      @(negedge clk);
      if (m_stb) stb_seen++;
      if (m_stb && m_ack) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got we=%0b addr=%h, required no transaction", m_we, m_addr);
        end else begin
          t = bus_q.pop_front();
          $display("bus %s addr=%h data=%h", m_we ? "WR" : "RD", m_addr, m_we ? m_dout : m_din);
          check("bus_txn", {9'h0, m_we, m_addr, m_we ? m_dout : m_din}, {9'h0, t});
        end
      end
      if (stb && !we && rd_q.size() > 0) begin
        e = rd_q.pop_front();
        n = rd_n.pop_front();
        $display("read %s reg=%0d data=%h", n, addr, data_out);
        check(n, {32'h0, data_out}, {32'h0, e});
        check("ack_eq_stb", {63'h0, ack}, 64'h1);
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    stb = 1; we = 1; addr = a; data_in = d;
    @(posedge clk); #1;
    stb = 0; we = 0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
    rd_q.push_back(e);
    rd_n.push_back(n);
    stb = 1; we = 0; addr = a;
    @(posedge clk); #1;
    stb = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_copy(input logic [21:0] s, input logic [21:0] d, input int n, input int p0);
    for (int i = 0; i < n; i++) begin
      bus_q.push_back('{we: 1'b0, a: s + 22'(i), d: pat(p0 + i)});
      bus_q.push_back('{we: 1'b1, a: d + 22'(i), d: pat(p0 + i)});
    end
  endtask

  task automatic drained(input string n);
    check(n, 64'(bus_q.size()), 64'h0);
    bus_q.delete();
  endtask

  initial begin
    int n;
    int s0;
`ifdef DMA_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    rst = 1; stb = 0; we = 0; addr = 0; data_in = 0;
    idle(3);
    check("rst_irq", {63'h0, irq}, 64'h0);
    check("rst_mstb", {62'h0, m_stb, m_we}, 64'h0);
    rst = 0;
    rd(0, 32'h0, "rst_src");
    rd(1, 32'h0, "rst_dst");
    rd(2, 32'h0, "rst_cnt");
    rd(3, 32'h0, "rst_stat");

    // 4-word copy 0x001000 -> 0x002000
    for (int i = 0; i < 4; i++) mem[22'h400 + 22'(i)] = pat(i);
    expect_copy(22'h400, 22'h800, 4, 0);
    wr(0, 32'h0000_1000);
    wr(1, 32'h0000_2000);
    wr(2, 32'd4);
    wr(3, 32'h1);
    idle(40);
    drained("copy_drained");
    for (int i = 0; i < 4; i++)
      check("copy_dst_mem", {32'h0, mem.exists(22'h800 + 22'(i)) ? mem[22'h800 + 22'(i)] : 32'hX}, {32'h0, pat(i)});
    rd(3, 32'h2, "copy_stat");
    rd(2, 32'h0, "copy_cnt");
    rd(0, 32'h0000_1010, "copy_src");
    rd(1, 32'h0000_2010, "copy_dst");

    // CNT=0 start: no bus activity, done two cycles later
    wr(3, 32'h8);
    rd(3, 32'h0, "clr_stat");
    wr(2, 32'h0);
    s0 = stb_seen;
    wr(3, 32'h1);
    idle(1);
    rd(3, 32'h2, "cnt0_stat");
    idle(4);
    check("cnt0_no_mstb", 64'(stb_seen - s0), 64'h0);

    // Abort after the second write ack of an 8-word copy
    for (int i = 0; i < 8; i++) mem[22'hC00 + 22'(i)] = pat(30 + i);
    expect_copy(22'hC00, 22'h1000, 2, 30);
    wr(0, 32'h0000_3000);
    wr(1, 32'h0000_4000);
    wr(2, 32'd8);
    wr(3, 32'h1);
    n = 0;
    for (int c = 0; c < 200 && n < 2; c++) begin
      @(negedge clk);
      if (m_stb && m_we && m_ack) n++;
    end
    check("abort_reach_wr2", 64'(n), 64'h2);
    wr(3, 32'h4);
    idle(10);
    drained("abort_drained");
    rd(2, 32'd6, "abort_cnt");
    rd(0, 32'h0000_3008, "abort_src");
    rd(1, 32'h0000_4008, "abort_dst");
    rd(3, 32'h2, "abort_stat");

    // Source address wrap at 0x3FFFFF
    mem[22'h3FFFFF] = pat(10);
    mem[22'h000000] = pat(11);
    expect_copy(22'h3FFFFF, 22'h1400, 1, 10);
    bus_q.push_back('{we: 1'b0, a: 22'h000000, d: pat(11)});
    bus_q.push_back('{we: 1'b1, a: 22'h001401, d: pat(11)});
    wr(0, 32'h00FF_FFFC);
    wr(1, 32'h0000_5000);
    wr(2, 32'd2);
    wr(3, 32'h1);
    idle(30);
    drained("wrap_drained");
    rd(0, 32'h0000_0004, "wrap_src");

    // Reset while stuck in WR with m_ack held low
    mem[22'h1800] = pat(20);
    bus_q.push_back('{we: 1'b0, a: 22'h1800, d: pat(20)});
    wr(0, 32'h0000_6000);
    wr(1, 32'h0000_7000);
    wr(2, 32'd1);
    wr(3, 32'h1);
    n = 0;
    for (int c = 0; c < 100 && n == 0; c++) begin
      @(negedge clk);
      if (m_stb && m_we) n = 1;
    end
    check("rst_reach_wr", 64'(n), 64'h1);
    hold = 1;
    rst  = 1;
    @(posedge clk); #1;
    check("rstwr_mstb", {62'h0, m_stb, m_we}, 64'h0);
    rst  = 0;
    hold = 0;
    drained("rstwr_drained");
    rd(0, 32'h0, "rstwr_src");
    rd(1, 32'h0, "rstwr_dst");
    rd(2, 32'h0, "rstwr_cnt");
    rd(3, 32'h0, "rstwr_stat");

    // 1-word copy with irq_en, then clear done
    expect_copy(22'h1800, 22'h1C00, 1, 20);
    wr(0, 32'h0000_6000);
    wr(1, 32'h0000_7000);
    wr(2, 32'd1);
    wr(3, 32'h3);
    idle(12);
    drained("irq_drained");
    check("irq_after_fin", {63'h0, irq}, {63'h0, exp_irq});
    rd(3, 32'h6, "irq_stat");
    wr(3, 32'h8);
    check("irq_cleared", {63'h0, irq}, 64'h0);
    rd(3, 32'h0, "irq_clr_stat");

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
